// File: rtl/store_unit.sv
// Store path: classifies and lane-aligns store requests, queues them in a small
// FIFO that drains into DMEM, and owns the CoreMark cycle counter behind TIMER_ADDR.
module store_unit #(
  parameter int unsigned BUF_DEPTH  = 2,
  parameter logic [31:0] TIMER_ADDR = 32'h0000FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_funct3,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_we,
  input  logic        dmem_ready,
  output logic        st_fault,
  output logic        buf_empty,
  output logic [31:0] coremark_count
);

  localparam int unsigned PW = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   OCC_ONE = 1;

  logic [31:0]   addr_mem [BUF_DEPTH];
  logic [31:0]   data_mem [BUF_DEPTH];
  logic [3:0]    we_mem   [BUF_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   occ_reg;
  logic          fault_reg;
  logic          running_reg;
  logic [31:0]   count_reg;

  logic        is_timer, illegal, misaligned, accept, push, pop, full, empty;
  logic [1:0]  off;
  logic [31:0] ent_wdata;
  logic [3:0]  ent_we;

  assign off        = st_addr[1:0];
  assign is_timer   = (st_addr == TIMER_ADDR);
  assign illegal    = !(st_funct3 == F3_SB || st_funct3 == F3_SH || st_funct3 == F3_SW);
  assign misaligned = (st_funct3 == F3_SH && off[0]) || (st_funct3 == F3_SW && off != 2'b00);

  // Depth is a power of two, so the occupancy MSB alone marks a full buffer.
  assign full     = occ_reg[PW];
  assign empty    = (occ_reg == '0);
  assign st_ready = is_timer || !full;
  assign accept   = st_valid && st_ready;
  assign push     = accept && !is_timer && !illegal && !misaligned;
  assign pop      = !empty && dmem_ready;

  always_comb begin
    ent_wdata = st_data;
    ent_we    = 4'b1111;
    case (st_funct3)
      F3_SB: begin
        ent_wdata = {4{st_data[7:0]}};
        ent_we    = 4'b0001 << off;
      end
      F3_SH: begin
        ent_wdata = {2{st_data[15:0]}};
        ent_we    = 4'b0011 << off;
      end
      default: begin
        ent_wdata = st_data;
        ent_we    = 4'b1111;
      end
    endcase
  end

  // Storage has no reset; occupancy alone decides whether an entry is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= {st_addr[31:2], 2'b00};
      data_mem[wr_ptr_reg] <= ent_wdata;
      we_mem[wr_ptr_reg]   <= ent_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      fault_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push && !pop)      occ_reg <= occ_reg + OCC_ONE;
      else if (pop && !push) occ_reg <= occ_reg - OCC_ONE;
      fault_reg <= accept && !is_timer && (illegal || misaligned);
    end
  end

  // Increment uses the running state from before this edge; a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      if (accept && is_timer && st_data[1]) count_reg <= '0;
      else if (running_reg)                 count_reg <= count_reg + 32'd1;
      if (accept && is_timer) running_reg <= st_data[0];
    end
  end

  assign dmem_addr      = empty ? 32'd0 : addr_mem[rd_ptr_reg];
  assign dmem_wdata     = empty ? 32'd0 : data_mem[rd_ptr_reg];
  assign dmem_we        = empty ? 4'd0  : we_mem[rd_ptr_reg];
  assign st_fault       = fault_reg;
  assign buf_empty      = empty;
  assign coremark_count = count_reg;

endmodule
